// File: rtl/fetch_redirect_pkg.sv
// rtl/fetch_redirect_pkg.sv - shared fetch pipeline types and constants
//
// Contents:
//   fr_state_t : redirect FSM state (RUN, SQUASH, PENDING), 2 bits
//   pc_sel_t   : PC register update selection (hold / increment / load)
//   PC_WIDTH   : program counter width
//   PC_INCR    : sequential fetch increment
//   align_word : clears the byte-offset bits of an address

package fetch_redirect_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SQUASH  = 2'd1,
        ST_PENDING = 2'd2
    } fr_state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_t;

    // Fetch addresses are always word aligned; masking (rather than slicing)
    // keeps every input bit consumed.
    function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_redirect_pc_register.sv
// rtl/fetch_redirect_pc_register.sv - program counter flop with hold/increment/load
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset, loads RESET_PC
//   sel       in   update selection (PC_HOLD, PC_INC, PC_LOAD)
//   loadValue in   value written when sel = PC_LOAD
//   pc        out  current program counter

module fetch_redirect_pc_register
    import fetch_redirect_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  pc_sel_t             sel,
    input  logic [PC_WIDTH-1:0] loadValue,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            case (sel)
                PC_INC:  pc <= pc + PC_INCR;
                PC_LOAD: pc <= loadValue;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_redirect.sv
// rtl/fetch_redirect.sv - fetch-side PC steering on ID-stage branch/jump decisions
//
// Owns the PC, redirects it to the ID-resolved target on a taken branch or
// jump, squashes the wrong-path instruction in IF/ID, and defers a redirect
// resolved during a stall until the stall releases.
//
// Optional feature: FETCH_REDIRECT_STATS_EN adds a committed-redirect counter
// on takenCountOutput; without it the port is tied to 0.
//
// Ports:
//   clock               in   rising-edge clock
//   reset               in   asynchronous active-high reset
//   stallInput          in   hazard stall, PC and pending state hold
//   branchTakenInput    in   taken decision from ID branch control
//   branchTargetInput   in   branch target computed in ID
//   jumpInput           in   unconditional jump resolved in ID
//   jumpTargetInput     in   jump target
//   pcOutput            out  current fetch address
//   pcPlus4Output       out  pcOutput + 4 (wraps)
//   flushIfIdOutput     out  load a bubble into IF/ID at the next edge
//   redirectValidOutput out  a redirect commits at the next edge
//   takenCountOutput    out  committed redirect count (stats builds only)

module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stallInput,
    input  logic                branchTakenInput,
    input  logic [PC_WIDTH-1:0] branchTargetInput,
    input  logic                jumpInput,
    input  logic [PC_WIDTH-1:0] jumpTargetInput,
    output logic [PC_WIDTH-1:0] pcOutput,
    output logic [PC_WIDTH-1:0] pcPlus4Output,
    output logic                flushIfIdOutput,
    output logic                redirectValidOutput,
    output logic [31:0]         takenCountOutput
);

    fr_state_t           state;
    fr_state_t           nextState;
    pc_sel_t             pcSel;
    logic [PC_WIDTH-1:0] pcLoad;
    logic [PC_WIDTH-1:0] pendingTarget;
    logic                latchPending;
    logic                req;
    logic [PC_WIDTH-1:0] target;

    // Jump wins over a simultaneous taken branch.
    assign req    = jumpInput | branchTakenInput;
    assign target = align_word(jumpInput ? jumpTargetInput : branchTargetInput);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState           = state;
        pcSel               = PC_HOLD;
        pcLoad              = target;
        latchPending        = 1'b0;
        flushIfIdOutput     = 1'b0;
        redirectValidOutput = 1'b0;
        case (state)
            ST_RUN: begin
                if (!stallInput) begin
                    if (req) begin
                        pcSel               = PC_LOAD;
                        flushIfIdOutput     = 1'b1;
                        redirectValidOutput = 1'b1;
                        nextState           = ST_SQUASH;
                    end else begin
                        pcSel = PC_INC;
                    end
                end else if (req) begin
                    latchPending = 1'b1;
                    nextState    = ST_PENDING;
                end
            end
            // ID holds the bubble; any request seen now belongs to the
            // squashed wrong-path instruction and is ignored.
            ST_SQUASH: begin
                if (!stallInput) begin
                    pcSel     = PC_INC;
                    nextState = ST_RUN;
                end
            end
            // The stalled branch is still in ID, so its latched target wins
            // over whatever the request lines show now.
            ST_PENDING: begin
                if (!stallInput) begin
                    pcSel               = PC_LOAD;
                    pcLoad              = pendingTarget;
                    flushIfIdOutput     = 1'b1;
                    redirectValidOutput = 1'b1;
                    nextState           = ST_SQUASH;
                end
            end
            default: begin
                nextState = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pendingTarget <= '0;
        end else if (latchPending) begin
            pendingTarget <= target;
        end
    end

    fetch_redirect_pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clock     (clock),
        .reset     (reset),
        .sel       (pcSel),
        .loadValue (pcLoad),
        .pc        (pcOutput)
    );

    assign pcPlus4Output = pcOutput + PC_INCR;

`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] takenCount;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            takenCount <= '0;
        end else if (redirectValidOutput) begin
            takenCount <= takenCount + 32'd1;
        end
    end

    assign takenCountOutput = takenCount;
`else
    assign takenCountOutput = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// tb/tb_fetch_redirect.sv - directed self-checking bench for fetch_redirect

module tb_fetch_redirect;

    logic        clock;
    logic        reset;
    logic        stallInput;
    logic        branchTakenInput;
    logic [31:0] branchTargetInput;
    logic        jumpInput;
    logic [31:0] jumpTargetInput;
    logic [31:0] pcOutput;
    logic [31:0] pcPlus4Output;
    logic        flushIfIdOutput;
    logic        redirectValidOutput;
    logic [31:0] takenCountOutput;

    int checks;
    int errors;
    int expCount;

    fetch_redirect #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .stallInput          (stallInput),
        .branchTakenInput    (branchTakenInput),
        .branchTargetInput   (branchTargetInput),
        .jumpInput           (jumpInput),
        .jumpTargetInput     (jumpTargetInput),
        .pcOutput            (pcOutput),
        .pcPlus4Output       (pcPlus4Output),
        .flushIfIdOutput     (flushIfIdOutput),
        .redirectValidOutput (redirectValidOutput),
        .takenCountOutput    (takenCountOutput)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic stall, input logic br, input logic [31:0] brT,
                         input logic jp, input logic [31:0] jpT);
        stallInput        = stall;
        branchTakenInput  = br;
        branchTargetInput = brT;
        jumpInput         = jp;
        jumpTargetInput   = jpT;
    endtask

    // Leaves the DUT in RUN with pcOutput = addr (jump to addr-4, then the
    // SQUASH cycle increments).
    task automatic goto_pc(input logic [31:0] addr);
        drive(0, 0, 0, 1, addr - 32'd4);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        expCount++;
    endtask

    function automatic logic [31:0] exp_stat();
`ifdef FETCH_REDIRECT_STATS_EN
        return expCount;
`else
        return 32'd0;
`endif
    endfunction

    task automatic test_reset();
        logic [31:0] expPc;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        checks++; if (pcOutput !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pcOutput, 32'h0); end
        checks++; if (pcPlus4Output !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h expected %h", pcPlus4Output, 32'h4); end
        checks++; if (flushIfIdOutput !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flushIfIdOutput); end
        checks++; if (redirectValidOutput !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b expected 0", redirectValidOutput); end
        checks++; if (takenCountOutput !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", takenCountOutput); end
        tick();
        reset = 1'b0;
        expCount = 0;
        #1;
        expPc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (pcOutput !== expPc) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pcOutput, expPc); end
            checks++; if (flushIfIdOutput !== 1'b0) begin errors++; $display("FAIL seq_flush[%0d]: got %b expected 0", i, flushIfIdOutput); end
            if (i < 3) tick();
            expPc = expPc + 32'd4;
        end
    endtask

    task automatic test_branch_commit();
        tick();
        checks++; if (pcOutput !== 32'h10) begin errors++; $display("FAIL br_start_pc: got %h expected %h", pcOutput, 32'h10); end
        drive(0, 1, 32'h40, 0, 0);
        #1;
        checks++; if (flushIfIdOutput !== 1'b1) begin errors++; $display("FAIL br_flush: got %b expected 1", flushIfIdOutput); end
        checks++; if (redirectValidOutput !== 1'b1) begin errors++; $display("FAIL br_redirect: got %b expected 1", redirectValidOutput); end
        tick();
        expCount++;
        drive(0, 0, 0, 0, 0);
        #1;
        checks++; if (pcOutput !== 32'h40) begin errors++; $display("FAIL br_target_pc: got %h expected %h", pcOutput, 32'h40); end
        checks++; if (flushIfIdOutput !== 1'b0) begin errors++; $display("FAIL br_squash_flush: got %b expected 0", flushIfIdOutput); end
        tick();
        checks++; if (pcOutput !== 32'h44) begin errors++; $display("FAIL br_next_pc: got %h expected %h", pcOutput, 32'h44); end
    endtask

    task automatic test_stalled_branch();
        goto_pc(32'h20);
        drive(1, 1, 32'h80, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (flushIfIdOutput !== 1'b0) begin errors++; $display("FAIL stall_flush[%0d]: got %b expected 0", i, flushIfIdOutput); end
            checks++; if (redirectValidOutput !== 1'b0) begin errors++; $display("FAIL stall_redirect[%0d]: got %b expected 0", i, redirectValidOutput); end
            checks++; if (pcOutput !== 32'h20) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pcOutput, 32'h20); end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        checks++; if (pcOutput !== 32'h20) begin errors++; $display("FAIL release_pc: got %h expected %h", pcOutput, 32'h20); end
        checks++; if (flushIfIdOutput !== 1'b1) begin errors++; $display("FAIL release_flush: got %b expected 1", flushIfIdOutput); end
        checks++; if (redirectValidOutput !== 1'b1) begin errors++; $display("FAIL release_redirect: got %b expected 1", redirectValidOutput); end
        tick();
        expCount++;
        checks++; if (pcOutput !== 32'h80) begin errors++; $display("FAIL pending_target_pc: got %h expected %h", pcOutput, 32'h80); end
        tick();
    endtask

    task automatic test_jump_priority();
        logic [31:0] jt [2];
        jt[0] = 32'h100;
        jt[1] = 32'h103;
        for (int r = 0; r < 2; r++) begin
            drive(0, 1, 32'h200, 1, jt[r]);
            #1;
            checks++; if (redirectValidOutput !== 1'b1) begin errors++; $display("FAIL jp_redirect[%0d]: got %b expected 1", r, redirectValidOutput); end
            tick();
            expCount++;
            drive(0, 0, 0, 0, 0);
            checks++; if (pcOutput !== 32'h100) begin errors++; $display("FAIL jp_pc[%0d]: got %h expected %h", r, pcOutput, 32'h100); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 32'h40, 0, 0);
        tick();
        expCount++;
        drive(0, 1, 32'h90, 0, 0);
        #1;
        checks++; if (pcOutput !== 32'h40) begin errors++; $display("FAIL b2b_pc0: got %h expected %h", pcOutput, 32'h40); end
        checks++; if (redirectValidOutput !== 1'b0) begin errors++; $display("FAIL b2b_redirect: got %b expected 0", redirectValidOutput); end
        checks++; if (flushIfIdOutput !== 1'b0) begin errors++; $display("FAIL b2b_flush: got %b expected 0", flushIfIdOutput); end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if (pcOutput !== 32'h44) begin errors++; $display("FAIL b2b_pc1: got %h expected %h", pcOutput, 32'h44); end
        checks++; if (takenCountOutput !== exp_stat()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", takenCountOutput, exp_stat()); end
    endtask

    task automatic test_reset_pending();
        goto_pc(32'h60);
        drive(1, 1, 32'h300, 0, 0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (pcOutput !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h expected %h", pcOutput, 32'h0); end
        checks++; if (takenCountOutput !== 32'h0) begin errors++; $display("FAIL async_reset_count: got %h expected 0", takenCountOutput); end
        expCount = 0;
        drive(0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (redirectValidOutput !== 1'b0) begin errors++; $display("FAIL post_reset_redirect: got %b expected 0", redirectValidOutput); end
        checks++; if (flushIfIdOutput !== 1'b0) begin errors++; $display("FAIL post_reset_flush: got %b expected 0", flushIfIdOutput); end
        tick();
        checks++; if (pcOutput !== 32'h4) begin errors++; $display("FAIL post_reset_pc: got %h expected %h", pcOutput, 32'h4); end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        checks++; if (pcOutput !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start_pc: got %h expected %h", pcOutput, 32'hFFFF_FFFC); end
        checks++; if (pcPlus4Output !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected 0", pcPlus4Output); end
        tick();
        checks++; if (pcOutput !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", pcOutput); end
        checks++; if (takenCountOutput !== exp_stat()) begin errors++; $display("FAIL final_count: got %0d expected %0d", takenCountOutput, exp_stat()); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        expCount = 0;
        test_reset();
        test_branch_commit();
        test_stalled_branch();
        test_jump_priority();
        test_back_to_back();
        test_reset_pending();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
